fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Sits between the PC-generating fetch stage and the decoder.
- Accepts PCs and issues in-order read requests to instruction memory, which has variable latency and a grant handshake.
- Holds issued/returned instructions in a DEPTH-entry in-order queue and presents them to the decoder with valid/ready.
- On a branch override (flush) it discards all queued entries and squashes responses still in flight.

Parameters:
- PC_WIDTH, 16, width of PC / instruction address.
- INSTR_WIDTH, 16, width of an instruction word.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset; asynchronous, active-low.
- pc_in  in  PC_WIDTH  next PC to fetch.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  pc_in accepted this cycle. Equals imem_req && imem_gnt.
- flush  in  1  branch override. Kills all queued and in-flight fetches.
- imem_req  out  1  read request.
- imem_addr  out  PC_WIDTH  request address; equals pc_in.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid. Strictly in order, at least 1 cycle after grant.
- imem_rdata  in  INSTR_WIDTH  read data.
- instr  out  INSTR_WIDTH  instruction at queue head.
- instr_pc  out  PC_WIDTH  PC of head instruction.
- instr_valid  out  1  head entry holds returned data.
- instr_ready  in  1  decoder consumes the head.
- protocol_err  out  1  sticky: a response arrived with nothing outstanding.

Behaviour:
- State:
  - Per entry: pc, instr, filled bit.
  - Pointers head, fill, tail, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - occupancy, 0..DEPTH.
  - squash, 0..DEPTH.
  - unfilled = entries between fill and tail.
- Reset (async, n_rst=0): all pointers, occupancy, squash, filled bits and protocol_err clear to 0. Outputs read 0: imem_req, pc_ready, instr_valid, instr, instr_pc. Reset mid-transaction abandons in-flight requests; memory is reset alongside.
- Issue:
  - imem_req = pc_valid && !flush && (occupancy + squash < DEPTH).
  - On imem_req && imem_gnt: write pc_in to entry[tail], clear its filled bit, advance tail, occupancy +1.
  - imem_req and imem_addr are combinational from pc_in/state. A request held without grant keeps the same address while pc_valid holds.
- Fill:
  - If imem_rvalid && squash>0: discard the data, squash -1.
  - Else if imem_rvalid && unfilled>0: write to entry[fill].instr, set filled, advance fill.
  - Else if imem_rvalid: set protocol_err; data dropped.
- Drain:
  - instr_valid = occupancy>0 && entry[head].filled.
  - instr and instr_pc come from entry[head].
  - On instr_valid && instr_ready: advance head, occupancy -1.
  - Data filled at edge N is visible at head from cycle N+1, so minimum grant-to-instr_valid latency is 2 cycles.
  - Issue, fill and drain may all occur in the same cycle. Occupancy nets +1, -1 or 0.
- Flush (flush=1, sampled at edge):
  - Same cycle: imem_req=0 and instr_valid=0. instr_ready is ignored.
  - At the edge: head=fill=tail=0, occupancy=0, all filled bits clear.
  - squash_next = squash + unfilled - (imem_rvalid ? 1 : 0). The response arriving in the flush cycle retires the oldest outstanding request, whether squash or unfilled.
  - Issue resumes the following cycle. Consecutive flush cycles accumulate correctly.
- Invariant: squash + unfilled <= DEPTH is guaranteed by the issue condition. The squash counter never overflows.
- Full (occupancy + squash == DEPTH): imem_req=0 and pc_ready=0. The fetch stage holds its PC.
- Empty, or head not yet filled: instr_valid=0.
- protocol_err clears only on reset.

Test Plan:
1. Streaming, 1-cycle latency: PCs 0x0010, 0x0011, 0x0012 granted back-to-back, rdata 0xA000+n, instr_ready=1. Required: instr/instr_pc pairs (0xA000,0x0010), (0xA001,0x0011), (0xA002,0x0012) in order; first instr_valid 2 cycles after first grant.
2. Backpressure to full: DEPTH=4, instr_ready=0, 4 grants plus responses. Required: pc_ready=0 while pc_valid=1 until one pop, then exactly one further grant.
3. Flush with 2 in flight: 1 entry filled and 2 unfilled, then flush=1 with no rvalid. Required: next cycle occupancy=0 and squash=2. The next 2 responses are discarded. A new PC 0x0200 issued after the flush returns with instr_pc=0x0200.
4. Flush coincident with rvalid: unfilled=1, squash=0, flush=1 and imem_rvalid=1 in the same cycle. Required: squash=0 afterwards, data dropped, instr_valid=0 next cycle.
5. Grant stall: pc_valid=1, imem_gnt=0 for 3 cycles. Required: imem_req=1 and imem_addr stable each cycle, pc_ready=0, then one entry allocated on the grant.
6. Error and async reset: imem_rvalid with an empty queue and squash=0 sets protocol_err=1. Asserting n_rst low mid-cycle, asynchronously, clears it immediately along with instr_valid.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : In-order instruction fetch queue between the PC generator and
//            the decoder. Issues granted read requests to instruction memory,
//            collects in-order responses and presents them with valid/ready.
//            A flush empties the queue and squashes responses still in flight.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic                   pc_valid,
    output logic                   pc_ready,
    input  logic                   flush,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   protocol_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] c_DEPTH = (CNT_W + 1)'(DEPTH);

    // Entry storage
    logic [PC_WIDTH-1:0]    r_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_ins   [DEPTH];
    logic [DEPTH-1:0]       r_filled;

    // Pointers and counters
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_fill;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_occ;    // allocated entries, 0..DEPTH
    logic [CNT_W-1:0] r_sq;     // responses still to be discarded, 0..DEPTH
    logic [CNT_W-1:0] r_unf;    // allocated entries waiting for data, 0..DEPTH
    logic             r_err;

    logic [CNT_W:0]   w_budget;
    logic [CNT_W-1:0] w_outst;
    logic [CNT_W-1:0] w_sq_flush;
    logic             w_req;
    logic             w_issue;
    logic             w_drop;
    logic             w_fill;
    logic             w_err;
    logic             w_valid;
    logic             w_pop;

    // Issue, fill, drain and flush decisions for the current cycle
    always_comb begin
        w_budget   = {1'b0, r_occ} + {1'b0, r_sq};
        // Squashed responses still occupy memory-side slots, so they count
        // against the budget alongside allocated entries.
        w_req      = pc_valid & ~flush & (w_budget < c_DEPTH);
        w_issue    = w_req & imem_gnt;
        w_drop     = imem_rvalid & ~flush & (r_sq != '0);
        w_fill     = imem_rvalid & ~flush & (r_sq == '0) & (r_unf != '0);
        // Nothing outstanding at all: holds whether or not a flush is active.
        w_err      = imem_rvalid & (r_sq == '0) & (r_unf == '0);
        w_valid    = ~flush & (r_occ != '0) & r_filled[r_head];
        w_pop      = w_valid & instr_ready;
        // On flush every unfilled entry becomes a response to squash; a
        // response arriving this same cycle retires the oldest of them.
        w_outst    = r_sq + r_unf;
        w_sq_flush = (imem_rvalid && (w_outst != '0)) ? (w_outst - 1'b1) : w_outst;
    end

    assign imem_req     = w_req;
    assign imem_addr    = pc_in;
    assign pc_ready     = w_issue;
    assign instr_valid  = w_valid;
    assign instr        = r_ins[r_head];
    assign instr_pc     = r_pc[r_head];
    assign protocol_err = r_err;

    // Pointer, counter and sticky error state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_head <= '0;
            r_fill <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_sq   <= '0;
            r_unf  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_err) begin
                r_err <= 1'b1;
            end
            if (flush) begin
                r_head <= '0;
                r_fill <= '0;
                r_tail <= '0;
                r_occ  <= '0;
                r_unf  <= '0;
                r_sq   <= w_sq_flush;
            end else begin
                if (w_issue) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_fill) begin
                    r_fill <= r_fill + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_drop) begin
                    r_sq <= r_sq - 1'b1;
                end
                r_occ <= r_occ + CNT_W'(w_issue) - CNT_W'(w_pop);
                r_unf <= r_unf + CNT_W'(w_issue) - CNT_W'(w_fill);
            end
        end
    end

    // Entry payload and filled flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]  <= '0;
                r_ins[i] <= '0;
            end
            r_filled <= '0;
        end else if (flush) begin
            r_filled <= '0;
        end else begin
            if (w_issue) begin
                r_pc[r_tail]     <= pc_in;
                r_filled[r_tail] <= 1'b0;
            end
            // Fill and issue never target the same slot: a fill needs an
            // unfilled entry, so fill != tail unless the queue is all unfilled
            // and full, in which case no issue is possible.
            if (w_fill) begin
                r_ins[r_fill]    <= imem_rdata;
                r_filled[r_fill] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Directed self-checking bench for fetch_queue with a queue-based
//            reference model compared on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int PW = 16;
    localparam int IW = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [PW-1:0] pc_in = '0;
    logic          pc_valid = 1'b0;
    logic          pc_ready;
    logic          flush = 1'b0;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic [IW-1:0] instr;
    logic [PW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          protocol_err;

    int n_chk = 0;
    int n_fail = 0;

    fetch_queue #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst),
        .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] ins;
        bit            filled;
    } ent_t;

    ent_t m_q[$];
    int   m_sq = 0;
    bit   m_err = 1'b0;

    function automatic int m_unfilled();
        int n = 0;
        foreach (m_q[i]) if (!m_q[i].filled) n++;
        return n;
    endfunction

    function automatic bit m_req();
        return pc_valid && !flush && ((m_q.size() + m_sq) < DEPTH);
    endfunction

    function automatic bit m_valid();
        return !flush && (m_q.size() > 0) && m_q[0].filled;
    endfunction

    // Model state advances on each clock edge from the inputs of that cycle
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_q.delete();
            m_sq  = 0;
            m_err = 1'b0;
        end else begin
            bit   v;
            bit   iss;
            int   u;
            ent_t e;
            v   = m_valid();
            iss = m_req() && imem_gnt;
            u   = m_unfilled();
            if (flush) begin
                if (imem_rvalid) begin
                    if (m_sq + u > 0) m_sq = m_sq + u - 1;
                    else m_err = 1'b1;
                end else begin
                    m_sq = m_sq + u;
                end
                m_q.delete();
            end else begin
                if (imem_rvalid) begin
                    if (m_sq > 0) m_sq--;
                    else if (u > 0) begin
                        for (int i = 0; i < m_q.size(); i++) begin
                            if (!m_q[i].filled) begin
                                e = m_q[i];
                                e.ins = imem_rdata;
                                e.filled = 1'b1;
                                m_q[i] = e;
                                break;
                            end
                        end
                    end else m_err = 1'b1;
                end
                if (v && instr_ready) void'(m_q.pop_front());
                if (iss) begin
                    e.pc = pc_in;
                    e.ins = '0;
                    e.filled = 1'b0;
                    m_q.push_back(e);
                end
            end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the edge
    always @(negedge clk) begin
        if (n_rst) begin
            chk("imem_req", 32'(imem_req), 32'(m_req()));
            chk("pc_ready", 32'(pc_ready), 32'(m_req() && imem_gnt));
            if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(pc_in));
            chk("instr_valid", 32'(instr_valid), 32'(m_valid()));
            if (m_valid()) begin
                chk("instr", 32'(instr), 32'(m_q[0].ins));
                chk("instr_pc", 32'(instr_pc), 32'(m_q[0].pc));
            end
            chk("protocol_err", 32'(protocol_err), 32'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit pv, input logic [PW-1:0] pc, input bit g,
                         input bit rv, input logic [IW-1:0] rd);
        pc_valid    = pv;
        pc_in       = pc;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        flush = 1'b0;
    endtask

    // Directed tests with hand-computed literal expectations
    initial begin
        // Reset state
        #12;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_err", 32'(protocol_err), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        step();

        // 1: streaming, 1-cycle memory latency
        instr_ready = 1'b1;
        drive(1'b1, 16'h0010, 1'b1, 1'b0, '0);
        chk("t1_gnt0", 32'(pc_ready), 32'd1);
        step();
        drive(1'b1, 16'h0011, 1'b1, 1'b1, 16'hA000);
        chk("t1_notyet", 32'(instr_valid), 32'd0);
        step();
        drive(1'b1, 16'h0012, 1'b1, 1'b1, 16'hA001);
        chk("t1_v0", 32'(instr_valid), 32'd1);
        chk("t1_i0", 32'(instr), 32'hA000);
        chk("t1_p0", 32'(instr_pc), 32'h0010);
        step();
        drive(1'b0, '0, 1'b0, 1'b1, 16'hA002);
        chk("t1_i1", 32'(instr), 32'hA001);
        chk("t1_p1", 32'(instr_pc), 32'h0011);
        step();
        idle();
        chk("t1_i2", 32'(instr), 32'hA002);
        chk("t1_p2", 32'(instr_pc), 32'h0012);
        step();
        chk("t1_empty", 32'(instr_valid), 32'd0);

        // 2: backpressure to full
        instr_ready = 1'b0;
        drive(1'b1, 16'h0020, 1'b1, 1'b0, '0);            step();
        drive(1'b1, 16'h0021, 1'b1, 1'b1, 16'hB000);      step();
        drive(1'b1, 16'h0022, 1'b1, 1'b1, 16'hB001);      step();
        drive(1'b1, 16'h0023, 1'b1, 1'b1, 16'hB002);      step();
        drive(1'b1, 16'h0024, 1'b1, 1'b1, 16'hB003);
        chk("t2_full_a", 32'(pc_ready), 32'd0);
        step();
        drive(1'b1, 16'h0024, 1'b1, 1'b0, '0);
        chk("t2_full_b", 32'(pc_ready), 32'd0);
        chk("t2_full_req", 32'(imem_req), 32'd0);
        step();
        instr_ready = 1'b1;
        #1;
        chk("t2_pop_cycle", 32'(pc_ready), 32'd0);
        chk("t2_head", 32'(instr), 32'hB000);
        step();
        instr_ready = 1'b0;
        #1;
        chk("t2_one_grant", 32'(pc_ready), 32'd1);
        step();
        chk("t2_full_again", 32'(pc_ready), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1, 16'hB004);
        step();
        idle();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // 3: flush with one filled and two unfilled entries
        instr_ready = 1'b0;
        drive(1'b1, 16'h0030, 1'b1, 1'b0, '0);            step();
        drive(1'b1, 16'h0031, 1'b1, 1'b1, 16'hC000);      step();
        drive(1'b1, 16'h0032, 1'b1, 1'b0, '0);            step();
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        flush = 1'b1;
        #1;
        chk("t3_flush_req", 32'(imem_req), 32'd0);
        chk("t3_flush_valid", 32'(instr_valid), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b1, 16'h0200, 1'b1, 1'b1, 16'hDEAD);
        chk("t3_reissue", 32'(pc_ready), 32'd1);
        step();
        drive(1'b0, '0, 1'b0, 1'b1, 16'hBEEF);
        chk("t3_squash_a", 32'(instr_valid), 32'd0);
        step();
        drive(1'b0, '0, 1'b0, 1'b1, 16'hC200);
        chk("t3_squash_b", 32'(instr_valid), 32'd0);
        step();
        idle();
        instr_ready = 1'b1;
        #1;
        chk("t3_valid", 32'(instr_valid), 32'd1);
        chk("t3_pc", 32'(instr_pc), 32'h0200);
        chk("t3_instr", 32'(instr), 32'hC200);
        chk("t3_noerr", 32'(protocol_err), 32'd0);
        step();

        // 4: flush coinciding with a response
        drive(1'b1, 16'h0040, 1'b1, 1'b0, '0);            step();
        drive(1'b0, '0, 1'b0, 1'b1, 16'hE000);
        flush = 1'b1;
        #1;
        chk("t4_flush_valid", 32'(instr_valid), 32'd0);
        step();
        idle();
        chk("t4_after_valid", 32'(instr_valid), 32'd0);
        chk("t4_err", 32'(protocol_err), 32'd0);
        step();
        drive(1'b1, 16'h0041, 1'b1, 1'b0, '0);            step();
        drive(1'b0, '0, 1'b0, 1'b1, 16'hE041);            step();
        idle();
        chk("t4_nosquash_v", 32'(instr_valid), 32'd1);
        chk("t4_nosquash_i", 32'(instr), 32'hE041);
        step();

        // 5: grant stall
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0050, 1'b0, 1'b0, '0);
            chk("t5_req", 32'(imem_req), 32'd1);
            chk("t5_addr", 32'(imem_addr), 32'h0050);
            chk("t5_ready", 32'(pc_ready), 32'd0);
            step();
        end
        drive(1'b1, 16'h0050, 1'b1, 1'b0, '0);
        chk("t5_grant", 32'(pc_ready), 32'd1);
        step();
        drive(1'b0, '0, 1'b0, 1'b1, 16'h5050);            step();
        idle();
        chk("t5_pc", 32'(instr_pc), 32'h0050);
        chk("t5_instr", 32'(instr), 32'h5050);
        step();

        // 6: stray response then asynchronous reset
        instr_ready = 1'b0;
        drive(1'b1, 16'h0060, 1'b1, 1'b0, '0);            step();
        drive(1'b0, '0, 1'b0, 1'b1, 16'h6060);            step();
        drive(1'b0, '0, 1'b0, 1'b1, 16'hFFFF);
        chk("t6_pre_err", 32'(protocol_err), 32'd0);
        step();
        idle();
        chk("t6_err", 32'(protocol_err), 32'd1);
        chk("t6_valid", 32'(instr_valid), 32'd1);
        step();
        chk("t6_sticky", 32'(protocol_err), 32'd1);
        #1;
        n_rst = 1'b0;
        #1;
        chk("t6_rst_err", 32'(protocol_err), 32'd0);
        chk("t6_rst_valid", 32'(instr_valid), 32'd0);
        chk("t6_rst_instr", 32'(instr), 32'd0);
        step();
        n_rst = 1'b1;
        step();
        chk("t6_after_err", 32'(protocol_err), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
